joybus_frame_receiver: RTL
==========================

Name: joybus_frame_receiver

Overview:
Parametrised receiver for single-wire controller frames (N64 joybus style). It decodes pulse-width-encoded bits on a raw, asynchronous data line into a FRAME_BITS-wide parallel word. It replaces the fixed 33-bit, externally clocked deserialiser: timing comes from the system clock, and the block adds frame validation, stuck-line timeout and error reporting. It sits between the controller pin and the button-mapping logic.

Parameters:
FRAME_BITS, 32, data bits per frame, excluding the stop bit; legal range 1..64.
BIT_THRESH, 100, low-time threshold in clocks; low < BIT_THRESH decodes '1', otherwise '0'.
TIMEOUT_CYCLES, 250, clocks of idle-high that end a frame, and clocks of low that flag a stuck line; must exceed BIT_THRESH.
SYNC_STAGES, 2, flip-flop stages in the input synchroniser; minimum 2.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
data_in  input  1  raw serial line, idle high, asynchronous
arm  input  1  one-cycle pulse that starts capture of the next frame
busy  output  1  high from accepted arm until frame_valid or frame_error
frame_data  output  FRAME_BITS  last good frame; first received bit is at MSB
frame_valid  output  1  one-cycle pulse when frame_data updates
frame_error  output  1  one-cycle pulse on a malformed or stuck frame
bit_count  output  $clog2(FRAME_BITS+2)  bits received in the current or last frame, including stop bit

Behaviour:
- Reset values (synchronous; a reset in the middle of a frame aborts it with no pulse):
  - state=IDLE; busy, frame_valid, frame_error, frame_data, bit_count all 0.
  - Synchroniser stages preset to 1 (line idle).
- All timing uses the synchronised line s_in. Its edges lag data_in by SYNC_STAGES clocks.
- States:
  - IDLE: ignore the line. Go to WAIT_FALL when arm=1. On the cycle after arm, busy=1 and bit_count=0.
  - WAIT_FALL: on a falling edge of s_in, clear low_cnt and go to MEAS_LOW. Wait indefinitely; there is no timeout here.
  - MEAS_LOW: low_cnt increments each cycle while s_in=0.
    - On a rising edge: the bit is (low_cnt < BIT_THRESH). Shift it into the shift register from the LSB end (so the first bit ends up at the MSB). Increment bit_count, clear high_cnt, go to MEAS_HIGH.
    - If low_cnt reaches TIMEOUT_CYCLES: go to ERROR.
  - MEAS_HIGH: high_cnt increments each cycle while s_in=1.
    - On a falling edge: clear low_cnt and go to MEAS_LOW.
    - If high_cnt reaches TIMEOUT_CYCLES: go to CHECK.
  - CHECK (1 cycle):
    - If bit_count == FRAME_BITS+1: frame_data = shift register bits [FRAME_BITS:1] (stop bit discarded). Pulse frame_valid and go to IDLE.
    - Otherwise: go to ERROR.
  - ERROR (1 cycle): pulse frame_error, leave frame_data unchanged, go to IDLE.
  - busy drops in the same cycle that frame_valid or frame_error is high.
- Counters:
  - low_cnt and high_cnt are $clog2(TIMEOUT_CYCLES+1) bits wide and saturate; they never wrap.
  - bit_count saturates at FRAME_BITS+1. Any further bits set an overflow flag, which forces ERROR in CHECK.
- Shift register is FRAME_BITS+1 bits wide.
- Latency: frame_valid asserts TIMEOUT_CYCLES+1 clocks after the stop bit's rising edge on s_in.
- Simultaneous events:
  - arm while busy: restart from WAIT_FALL, clear bit_count and overflow; no error pulse.
  - arm in the CHECK or ERROR cycle: that cycle's pulse still fires, then the block re-arms.
  - reset has priority over arm.
- frame_valid and frame_error never assert in the same cycle.

Decomposition:
- Package joybus_pkg holds:
  - the state enum (IDLE, WAIT_FALL, MEAS_LOW, MEAS_HIGH, CHECK, ERROR);
  - default timing constants for a 50 MHz clock (1 us = 50 clocks);
  - N64 field offsets within a 32-bit frame: buttons [31:16], stick X [15:8], stick Y [7:0].
- One sub-module: joybus_sync, a SYNC_STAGES-deep synchroniser with preset-high reset and a registered edge detector (rise/fall outputs).

Test Plan:
- Good frame at defaults: arm, then send 0x8000_1234 plus stop bit. Each '1' = 50 clocks low + 150 high; each '0' = 150 low + 50 high. -> frame_data=0x80001234, one frame_valid pulse, bit_count=33, busy low afterwards.
- Short frame: 20 bits, then line idle. -> frame_error pulse after 250 high cycles; frame_data keeps its previous value; bit_count=20.
- Stuck line: arm, then hold data_in low for 300 clocks. -> frame_error once low_cnt reaches 250; state returns to IDLE.
- Threshold boundary: a bit with low time 99 synchronised clocks decodes '1'; a bit with low time 100 decodes '0'. Check with FRAME_BITS=1 (two pulses per frame).
- Re-arm mid-frame: pulse arm after 10 bits, then send a full good frame. -> no error pulse; only the second frame is captured.
- Reset mid-frame: assert reset during bit 15. -> all outputs 0 on the next cycle; a later line frame without arm produces no pulse.

Source files
------------

// File: rtl/joybus_pkg.sv
// Shared definitions for the joybus controller-frame receiver: FSM states,
// default 50 MHz timing constants and N64 field offsets within a 32-bit frame.
package joybus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FALL,
        MEAS_LOW,
        MEAS_HIGH,
        CHECK,
        ERROR
    } state_e;

    // 50 MHz system clock: 1 us of line time is 50 clocks
    localparam int CLOCKS_PER_US       = 50;
    localparam int DEFAULT_FRAME_BITS  = 32;
    localparam int DEFAULT_BIT_THRESH  = 2 * CLOCKS_PER_US;
    localparam int DEFAULT_TIMEOUT     = 5 * CLOCKS_PER_US;
    localparam int DEFAULT_SYNC_STAGES = 2;

    localparam int BUTTONS_MSB = 31;
    localparam int BUTTONS_LSB = 16;
    localparam int STICK_X_MSB = 15;
    localparam int STICK_X_LSB = 8;
    localparam int STICK_Y_MSB = 7;
    localparam int STICK_Y_LSB = 0;

endpackage

// File: rtl/joybus_sync.sv
// Multi-stage synchroniser for the asynchronous joybus line, preset to the idle
// level, followed by an edge detector built on a registered copy of the output.
module joybus_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], line_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/joybus_frame_receiver.sv
// Pulse-width joybus frame receiver: measures low/high times of the synchronised
// line, shifts decoded bits in MSB-first and validates the frame on idle timeout.
module joybus_frame_receiver
    import joybus_pkg::*;
#(
    parameter int FRAME_BITS     = DEFAULT_FRAME_BITS,
    parameter int BIT_THRESH     = DEFAULT_BIT_THRESH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              data_in,
    input  logic                              arm,
    output logic                              busy,
    output logic [FRAME_BITS-1:0]             frame_data,
    output logic                              frame_valid,
    output logic                              frame_error,
    output logic [$clog2(FRAME_BITS+2)-1:0]   bit_count
);

    localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BCW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [BCW-1:0] BC_FULL = BCW'(FRAME_BITS + 1);

    state_e                state_q;
    logic                  busy_q;
    logic                  frame_valid_q;
    logic                  frame_error_q;
    logic [FRAME_BITS-1:0] frame_data_q;
    logic [BCW-1:0]        bit_count_q;
    logic                  ovf_q;
    logic [FRAME_BITS:0]   shift_q;
    logic [CW-1:0]         low_cnt_q;
    logic [CW-1:0]         high_cnt_q;

    logic sIn;
    logic sRise;
    logic sFall;
    logic lowBit;
    logic lowTimeout;
    logic highTimeout;

    joybus_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .line_i  (data_in),
        .level_o (sIn),
        .rise_o  (sRise),
        .fall_o  (sFall)
    );

    // The counters miss the edge cycle itself, so the measured time is count+1
    assign lowBit      = (int'(low_cnt_q) + 1) < BIT_THRESH;
    assign lowTimeout  = (int'(low_cnt_q) + 1) >= TIMEOUT_CYCLES;
    assign highTimeout = (int'(high_cnt_q) + 1) >= TIMEOUT_CYCLES;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            frame_data_q  <= '0;
            bit_count_q   <= '0;
            ovf_q         <= 1'b0;
            shift_q       <= '0;
            low_cnt_q     <= '0;
            high_cnt_q    <= '0;
        end else begin
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            if (arm) begin
                state_q     <= WAIT_FALL;
                busy_q      <= 1'b1;
                bit_count_q <= '0;
                ovf_q       <= 1'b0;
            end else begin
                case (state_q)
                    WAIT_FALL: begin
                        if (sFall) begin
                            low_cnt_q <= '0;
                            state_q   <= MEAS_LOW;
                        end
                    end
                    MEAS_LOW: begin
                        if (sRise) begin
                            shift_q    <= {shift_q[FRAME_BITS-1:0], lowBit};
                            high_cnt_q <= '0;
                            state_q    <= MEAS_HIGH;
                            if (bit_count_q == BC_FULL) begin
                                ovf_q <= 1'b1;
                            end else begin
                                bit_count_q <= bit_count_q + 1'b1;
                            end
                        end else if (lowTimeout) begin
                            frame_error_q <= 1'b1;
                            busy_q        <= 1'b0;
                            state_q       <= ERROR;
                        end else if (low_cnt_q != CNT_MAX) begin
                            low_cnt_q <= low_cnt_q + 1'b1;
                        end
                    end
                    MEAS_HIGH: begin
                        if (sFall) begin
                            low_cnt_q <= '0;
                            state_q   <= MEAS_LOW;
                        end else if (highTimeout) begin
                            busy_q <= 1'b0;
                            // Validation happens on entry so the pulse is visible during CHECK/ERROR
                            if (bit_count_q == BC_FULL && !ovf_q) begin
                                frame_data_q  <= shift_q[FRAME_BITS:1];
                                frame_valid_q <= 1'b1;
                                state_q       <= CHECK;
                            end else begin
                                frame_error_q <= 1'b1;
                                state_q       <= ERROR;
                            end
                        end else if (high_cnt_q != CNT_MAX) begin
                            high_cnt_q <= high_cnt_q + 1'b1;
                        end
                    end
                    CHECK, ERROR: state_q <= IDLE;
                    default:      state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy        = busy_q;
    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_error = frame_error_q;
    assign bit_count   = bit_count_q;

endmodule
